udp_rx: RTL and testbench
=========================

# udp_rx

UDP receive stage, directly downstream of the IPv4 receive filter. Consumes the IPv4 payload stream (16-bit words), parses and strips the 8-byte UDP header, filters on destination port and delivers the UDP payload to the application with start/end framing and a length-error flag. The UDP checksum is not verified: no pseudo-header is available at this stage.

## Interface
- DATA_W, 16: data path width; only 16 is supported.
- LEN_W, 2: byte-count width; len value 1 or 2.
- PORT_W, 16: UDP port field width.
- PORT, 16'd18000: accepted destination port.

- clk  in  1  clock.
- nreset  in  1  reset, synchronous, active-low.
- cancel_i  in  1  abort of the current packet by the upstream stage.
- valid_i  in  1  input word valid.
- data_i  in  DATA_W  IPv4 payload word; first byte on data_i[7:0], second on data_i[15:8].
- len_i  in  LEN_W  valid bytes in the word: 2, or 1 on the final word only (lane 0 valid).
- last_i  in  1  qualifies valid_i: final word of the IPv4 payload.
- valid_o  out  1  payload word valid.
- data_o  out  DATA_W  payload word, same lane order as data_i.
- len_o  out  LEN_W  valid payload bytes in data_o (1 or 2).
- start_o  out  1  first payload word of a datagram.
- end_o  out  1  last payload word of a datagram.
- err_o  out  1  length error, 1-cycle pulse.
- cancel_o  out  1  the datagram in flight is aborted; the consumer drops it.
- src_port_o  out  PORT_W  source port of the current datagram, held until the next header.

## Operation
- 16-bit fields are network order: value = {data_i[7:0], data_i[15:8]}.
- States: IDLE, HEAD, DATA, DISCARD (one-hot).
- IDLE, valid_i: word 0 = source port, captured into src_port_q. Next state HEAD, hcnt=1.
- HEAD: valid words increment hcnt.
  - hcnt=1: destination port; mismatch sets drop_q.
  - hcnt=2: UDP length captured into ulen_q (16 bit).
  - hcnt=3: checksum, ignored.
- After the hcnt=3 word:
  - ulen_q<8: err_o pulse, go to DISCARD.
  - drop_q set: go to DISCARD, no err_o.
  - ulen_q==8: empty datagram, no output, go to DISCARD.
  - Otherwise: load rem_q = ulen_q-8 and go to DATA.
- DATA, per valid word:
  - obytes = min(len_i, rem_q); rem_q -= obytes.
  - The word is forwarded with len_o=obytes.
  - start_o is set on the first DATA word.
  - When rem_q reaches 0, end_o is set and the next state is DISCARD. Trailing bytes up to last_i are discarded (IP payload longer than UDP length).
- DISCARD: consumes words with no output.
- last_i handling:
  - valid_i & last_i in any state ends the packet and returns to IDLE.
  - last_i in DATA with rem_q not reaching 0 on that word: truncated datagram. The word is forwarded with end_o=1 and err_o=1.
  - last_i in IDLE or HEAD before the header completes: err_o pulse, no payload output.
  - last_i on the word that zeroes rem_q: normal end, go to IDLE.
- cancel_i has priority over everything, in any state. Next state IDLE; drop_q is cleared.
  - cancel_o pulses (registered) only if start_o has already been issued for this datagram without end_o.
  - A valid_i on the cancel_i cycle is ignored.
- rem_q subtraction never underflows: obytes is clamped. ulen_q is compared as unsigned.

## Timing
- All outputs registered; one-cycle latency from a data_i word to data_o.
- Outputs are combinational-free.
- No backpressure: the block accepts a word every cycle valid_i is high.
- Idle cycles (valid_i low) are allowed anywhere; no state change on such cycles.
- Reset values: valid_o, start_o, end_o, err_o, cancel_o = 0; data_o, len_o, src_port_o = 0.
- Internal reset: state = IDLE, hcnt = 0, rem_q = 0, drop_q = 0.
- Reset mid-packet: the block returns to IDLE with no end_o or cancel_o emitted. The next valid_i after reset is treated as header word 0.
- start_o and end_o may be asserted on the same word (payload of 1 or 2 bytes).
- Back-to-back packets are supported: the cycle after a last_i word may carry word 0 of the next packet.

## Test plan
- Port 18000 (0x4650), ulen=12, payload AA BB CC DD, last_i on the final word:
  - two valid_o words, data_o 0xBBAA then 0xDDCC, len_o 2;
  - start_o on word 1, end_o on word 2;
  - src_port_o = captured value.
- ulen=11, three payload bytes, final word len_i=1 -> second output word len_o=1 with end_o; no err_o.
- Destination port 53 -> no valid_o for the whole packet; the next matching packet is delivered normally.
- ulen=20 but last_i after 4 payload bytes -> the final forwarded word carries end_o=1 and err_o=1.
- ulen=10 with IP payload 14 bytes -> 1 payload word with end_o; the remaining words are silently dropped until last_i; no err_o.
- cancel_i after the first payload word -> cancel_o pulses once, state returns to IDLE. A following packet with ulen=8 produces no output.

Source files
------------

// File: rtl/udp_rx.sv
// UDP receive stage: parses and strips the 8-byte UDP header, filters on destination port and
// forwards the payload with start/end framing, length-error and cancel indications.
module udp_rx #(
   parameter int unsigned       DATA_W = 16,
   parameter int unsigned       LEN_W  = 2,
   parameter int unsigned       PORT_W = 16,
   parameter logic [PORT_W-1:0] PORT   = 16'd18000
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              cancel_i,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic              last_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic [LEN_W-1:0]  len_o,
   output logic              start_o,
   output logic              end_o,
   output logic              err_o,
   output logic              cancel_o,
   output logic [PORT_W-1:0] src_port_o
);

   localparam int unsigned ULEN_W = 16;

   typedef enum logic [3:0] {
      StIdle    = 4'b0001,
      StHead    = 4'b0010,
      StData    = 4'b0100,
      StDiscard = 4'b1000
   } state_e;

   state_e              state_q, state_d;
   logic [1:0]          hcnt_q, hcnt_d;
   logic [ULEN_W-1:0]   rem_q, rem_d;
   logic [ULEN_W-1:0]   ulen_q, ulen_d;
   logic                drop_q, drop_d;
   logic                first_q, first_d;
   // open: start_o issued for the current datagram and end_o not yet issued
   logic                open_q, open_d;
   logic [PORT_W-1:0]   src_port_q, src_port_d;

   logic                valid_q, valid_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic                start_q, start_d;
   logic                end_q, end_d;
   logic                err_q, err_d;
   logic                cancel_q, cancel_d;

   logic [15:0]         field;
   logic [LEN_W-1:0]    obytes;
   logic [ULEN_W-1:0]   rem_next;

   // Header fields are big-endian: first byte on the wire is the high byte.
   assign field = {data_i[7:0], data_i[15:8]};

   always_comb begin
      obytes = len_i;
      if (rem_q < ULEN_W'(len_i)) begin
         obytes = rem_q[LEN_W-1:0];
      end
      rem_next = rem_q - ULEN_W'(obytes);
   end

   always_comb begin
      state_d    = state_q;
      hcnt_d     = hcnt_q;
      rem_d      = rem_q;
      ulen_d     = ulen_q;
      drop_d     = drop_q;
      first_d    = first_q;
      open_d     = open_q;
      src_port_d = src_port_q;
      valid_d    = 1'b0;
      data_d     = data_q;
      len_d      = len_q;
      start_d    = 1'b0;
      end_d      = 1'b0;
      err_d      = 1'b0;
      cancel_d   = 1'b0;

      if (cancel_i) begin
         state_d  = StIdle;
         hcnt_d   = 2'd0;
         drop_d   = 1'b0;
         first_d  = 1'b0;
         open_d   = 1'b0;
         cancel_d = open_q;
      end else if (valid_i) begin
         unique case (state_q)
            StIdle: begin
               src_port_d = field[PORT_W-1:0];
               drop_d     = 1'b0;
               if (last_i) begin
                  err_d = 1'b1;
               end else begin
                  state_d = StHead;
                  hcnt_d  = 2'd1;
               end
            end
            StHead: begin
               hcnt_d = hcnt_q + 2'd1;
               if (hcnt_q == 2'd1 && field[PORT_W-1:0] != PORT) begin
                  drop_d = 1'b1;
               end
               if (hcnt_q == 2'd2) begin
                  ulen_d = field;
               end
               if (hcnt_q == 2'd3) begin
                  hcnt_d = 2'd0;
                  if (ulen_q < ULEN_W'(8)) begin
                     err_d   = 1'b1;
                     state_d = StDiscard;
                  end else if (drop_q || ulen_q == ULEN_W'(8)) begin
                     state_d = StDiscard;
                  end else begin
                     rem_d   = ulen_q - ULEN_W'(8);
                     first_d = 1'b1;
                     state_d = StData;
                     // Payload promised but the packet ends with the header.
                     err_d   = last_i;
                  end
               end else if (last_i) begin
                  err_d = 1'b1;
               end
               if (last_i) begin
                  state_d = StIdle;
                  hcnt_d  = 2'd0;
                  first_d = 1'b0;
               end
            end
            StData: begin
               valid_d = 1'b1;
               data_d  = data_i;
               len_d   = obytes;
               start_d = first_q;
               first_d = 1'b0;
               rem_d   = rem_next;
               open_d  = 1'b1;
               if (rem_next == '0) begin
                  end_d   = 1'b1;
                  open_d  = 1'b0;
                  state_d = last_i ? StIdle : StDiscard;
               end else if (last_i) begin
                  end_d   = 1'b1;
                  err_d   = 1'b1;
                  open_d  = 1'b0;
                  state_d = StIdle;
               end
            end
            StDiscard: begin
               if (last_i) begin
                  state_d = StIdle;
               end
            end
            default: begin
               state_d = StIdle;
               hcnt_d  = 2'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q    <= StIdle;
         hcnt_q     <= 2'd0;
         rem_q      <= '0;
         ulen_q     <= '0;
         drop_q     <= 1'b0;
         first_q    <= 1'b0;
         open_q     <= 1'b0;
         src_port_q <= '0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         len_q      <= '0;
         start_q    <= 1'b0;
         end_q      <= 1'b0;
         err_q      <= 1'b0;
         cancel_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         hcnt_q     <= hcnt_d;
         rem_q      <= rem_d;
         ulen_q     <= ulen_d;
         drop_q     <= drop_d;
         first_q    <= first_d;
         open_q     <= open_d;
         src_port_q <= src_port_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         len_q      <= len_d;
         start_q    <= start_d;
         end_q      <= end_d;
         err_q      <= err_d;
         cancel_q   <= cancel_d;
      end
   end

   assign valid_o    = valid_q;
   assign data_o     = data_q;
   assign len_o      = len_q;
   assign start_o    = start_q;
   assign end_o      = end_q;
   assign err_o      = err_q;
   assign cancel_o   = cancel_q;
   assign src_port_o = src_port_q;

endmodule

// File: tb/tb_udp_rx.sv
// Directed self-checking bench for udp_rx: header parsing, port filter, length handling,
// truncation, cancel and reset behaviour.
module tb_udp_rx;

   logic        clk = 1'b0;
   logic        nreset;
   logic        cancel_i;
   logic        valid_i;
   logic [15:0] data_i;
   logic [1:0]  len_i;
   logic        last_i;
   logic        valid_o;
   logic [15:0] data_o;
   logic [1:0]  len_o;
   logic        start_o;
   logic        end_o;
   logic        err_o;
   logic        cancel_o;
   logic [15:0] src_port_o;

   int n_checks = 0;
   int n_pass   = 0;
   int vcount   = 0;
   int ecount   = 0;
   int ccount   = 0;

   always #5 clk = ~clk;

   udp_rx #(
      .DATA_W(16),
      .LEN_W (2),
      .PORT_W(16),
      .PORT  (16'd18000)
   ) dut (
      .clk       (clk),
      .nreset    (nreset),
      .cancel_i  (cancel_i),
      .valid_i   (valid_i),
      .data_i    (data_i),
      .len_i     (len_i),
      .last_i    (last_i),
      .valid_o   (valid_o),
      .data_o    (data_o),
      .len_o     (len_o),
      .start_o   (start_o),
      .end_o     (end_o),
      .err_o     (err_o),
      .cancel_o  (cancel_o),
      .src_port_o(src_port_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] net(input logic [15:0] v);
      return {v[7:0], v[15:8]};
   endfunction

   // Inputs change at a falling edge; after the next falling edge the registered outputs
   // reflect exactly this word.
   task automatic drive(input logic v, input logic [15:0] d, input logic [1:0] l,
                        input logic la, input logic c);
      valid_i  = v;
      data_i   = d;
      len_i    = l;
      last_i   = la;
      cancel_i = c;
      @(negedge clk);
      if (valid_o) vcount++;
      if (err_o) ecount++;
      if (cancel_o) ccount++;
   endtask

   task automatic idle();
      drive(1'b0, 16'h0000, 2'd0, 1'b0, 1'b0);
   endtask

   task automatic hdr(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] ulen);
      drive(1'b1, net(src), 2'd2, 1'b0, 1'b0);
      drive(1'b1, net(dst), 2'd2, 1'b0, 1'b0);
      drive(1'b1, net(ulen), 2'd2, 1'b0, 1'b0);
      drive(1'b1, 16'h0000, 2'd2, 1'b0, 1'b0);
   endtask

   task automatic clr();
      vcount = 0;
      ecount = 0;
      ccount = 0;
   endtask

   initial begin
      nreset   = 1'b0;
      cancel_i = 1'b0;
      valid_i  = 1'b0;
      data_i   = 16'h0;
      len_i    = 2'd0;
      last_i   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_data", 32'(data_o), 32'd0);
      check("rst_len", 32'(len_o), 32'd0);
      check("rst_flags", {28'd0, start_o, end_o, err_o, cancel_o}, 32'd0);
      check("rst_src", 32'(src_port_o), 32'd0);
      nreset = 1'b1;
      idle();

      // Basic datagram: 4 payload bytes.
      clr();
      hdr(16'h1234, 16'd18000, 16'd12);
      check("t1_hdr_quiet", 32'(vcount), 32'd0);
      drive(1'b1, 16'hBBAA, 2'd2, 1'b0, 1'b0);
      check("t1_w1_valid", 32'(valid_o), 32'd1);
      check("t1_w1_data", 32'(data_o), 32'hBBAA);
      check("t1_w1_len", 32'(len_o), 32'd2);
      check("t1_w1_start", 32'(start_o), 32'd1);
      check("t1_w1_end", 32'(end_o), 32'd0);
      check("t1_src", 32'(src_port_o), 32'h1234);
      drive(1'b1, 16'hDDCC, 2'd2, 1'b1, 1'b0);
      check("t1_w2_data", 32'(data_o), 32'hDDCC);
      check("t1_w2_flags", {28'd0, valid_o, start_o, end_o, err_o}, 32'b1010);
      check("t1_w2_len", 32'(len_o), 32'd2);
      idle();
      check("t1_after", 32'(valid_o), 32'd0);

      // Odd length: 3 payload bytes.
      hdr(16'h0001, 16'd18000, 16'd11);
      drive(1'b1, 16'h2211, 2'd2, 1'b0, 1'b0);
      check("t2_w1_start", 32'(start_o), 32'd1);
      drive(1'b1, 16'h0033, 2'd1, 1'b1, 1'b0);
      check("t2_w2_len", 32'(len_o), 32'd1);
      check("t2_w2_flags", {28'd0, valid_o, start_o, end_o, err_o}, 32'b1010);
      check("t2_w2_data", 32'(data_o), 32'h0033);
      idle();

      // Wrong port filtered, then a matching 2-byte datagram.
      clr();
      hdr(16'h0002, 16'd53, 16'd12);
      drive(1'b1, 16'h1111, 2'd2, 1'b0, 1'b0);
      drive(1'b1, 16'h2222, 2'd2, 1'b1, 1'b0);
      idle();
      check("t3_drop_valid", 32'(vcount), 32'd0);
      check("t3_drop_err", 32'(ecount), 32'd0);
      hdr(16'h0BAD, 16'd18000, 16'd10);
      drive(1'b1, 16'h5566, 2'd2, 1'b1, 1'b0);
      check("t3_next_flags", {28'd0, valid_o, start_o, end_o, err_o}, 32'b1110);
      check("t3_next_data", 32'(data_o), 32'h5566);
      check("t3_next_src", 32'(src_port_o), 32'h0BAD);
      idle();

      // Truncated: ulen 20 but only 4 payload bytes.
      hdr(16'h0003, 16'd18000, 16'd20);
      drive(1'b1, 16'h0201, 2'd2, 1'b0, 1'b0);
      drive(1'b1, 16'h0403, 2'd2, 1'b1, 1'b0);
      check("t4_trunc_flags", {28'd0, valid_o, start_o, end_o, err_o}, 32'b1011);
      idle();
      check("t4_err_pulse", 32'(err_o), 32'd0);

      // IP payload longer than UDP length: trailing words dropped.
      clr();
      hdr(16'h0004, 16'd18000, 16'd10);
      drive(1'b1, 16'h7788, 2'd2, 1'b0, 1'b0);
      check("t5_w1_flags", {28'd0, valid_o, start_o, end_o, err_o}, 32'b1110);
      drive(1'b1, 16'h99AA, 2'd2, 1'b0, 1'b0);
      drive(1'b1, 16'hBBCC, 2'd2, 1'b1, 1'b0);
      idle();
      check("t5_count", 32'(vcount), 32'd1);
      check("t5_err", 32'(ecount), 32'd0);

      // Cancel after the first payload word, then an empty datagram.
      hdr(16'h0005, 16'd18000, 16'd20);
      drive(1'b1, 16'h0101, 2'd2, 1'b0, 1'b0);
      check("t6_start", 32'(start_o), 32'd1);
      clr();
      drive(1'b1, 16'h0202, 2'd2, 1'b0, 1'b1);
      check("t6_cancel", 32'(cancel_o), 32'd1);
      check("t6_cancel_novalid", 32'(valid_o), 32'd0);
      idle();
      check("t6_cancel_pulse", 32'(cancel_o), 32'd0);
      drive(1'b1, net(16'h0006), 2'd2, 1'b0, 1'b0);
      drive(1'b1, net(16'd18000), 2'd2, 1'b0, 1'b0);
      drive(1'b1, net(16'd8), 2'd2, 1'b0, 1'b0);
      drive(1'b1, 16'h0000, 2'd2, 1'b1, 1'b0);
      idle();
      check("t6_empty_valid", 32'(vcount), 32'd0);
      check("t6_empty_err", 32'(ecount), 32'd0);
      check("t6_cancel_count", 32'(ccount), 32'd1);
      check("t6_src", 32'(src_port_o), 32'h0006);

      // last_i inside the header.
      clr();
      drive(1'b1, net(16'h0007), 2'd2, 1'b0, 1'b0);
      drive(1'b1, net(16'd18000), 2'd2, 1'b1, 1'b0);
      check("t7_hdr_last_err", 32'(err_o), 32'd1);
      idle();
      // Cancel in the header without an open datagram: no cancel_o.
      drive(1'b1, net(16'h0008), 2'd2, 1'b0, 1'b0);
      drive(1'b1, 16'h0000, 2'd2, 1'b0, 1'b1);
      check("t7_cancel_hdr", 32'(cancel_o), 32'd0);
      // ulen below the header size.
      hdr(16'h0009, 16'd18000, 16'd6);
      check("t7_short_err", 32'(err_o), 32'd1);
      drive(1'b1, 16'h4444, 2'd2, 1'b1, 1'b0);
      idle();
      check("t7_no_valid", 32'(vcount), 32'd0);
      check("t7_no_cancel", 32'(ccount), 32'd0);

      // Reset mid-datagram, then a 1-byte datagram.
      clr();
      hdr(16'h000A, 16'd18000, 16'd20);
      drive(1'b1, 16'h0303, 2'd2, 1'b0, 1'b0);
      nreset = 1'b0;
      idle();
      check("t8_rst_flags", {28'd0, valid_o, end_o, err_o, cancel_o}, 32'd0);
      nreset = 1'b1;
      hdr(16'h000B, 16'd18000, 16'd9);
      drive(1'b1, 16'h00EE, 2'd1, 1'b1, 1'b0);
      check("t8_flags", {28'd0, valid_o, start_o, end_o, err_o}, 32'b1110);
      check("t8_len", 32'(len_o), 32'd1);
      check("t8_data", 32'(data_o), 32'h00EE);
      check("t8_src", 32'(src_port_o), 32'h000B);
      idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
